// File: rtl/spart_bus_ctrl.sv
// Processor-side serial port controller: bus register decode, baud divisor,
// TX/RX baud enable generation, received-byte buffering and TX load sequencing.
module spart_bus_ctrl #(
   parameter int DIV_W     = 16,
   parameter int RESET_DIV = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       rda_o,
   output logic       tbr_o,
   input  logic       rxd,
   input  logic [7:0] rx_byte,
   input  logic       rx_rda,
   output logic       rx_baud_en,
   output logic [7:0] tx_data,
   output logic       tx_load,
   input  logic       tx_ready,
   output logic       tx_baud_en
);

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_TWO   = DIV_W'(2);
   localparam logic [DIV_W:0]   EXT_ZERO  = {(DIV_W+1){1'b0}};
   localparam logic [DIV_W:0]   EXT_ONE   = (DIV_W+1)'(1);

   typedef enum logic [1:0] {
      RX_IDLE = 2'b00,
      RX_RUN  = 2'b01,
      RX_STOP = 2'b10
   } rx_state_t;

   rx_state_t         r_rx_state, w_rx_state_nxt;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  w_d;
   logic [DIV_W:0]    w_d_ext;
   logic [15:0]       w_div16;
   logic [15:0]       w_div16_wr;
   logic [DIV_W-1:0]  r_tx_cnt;
   logic [DIV_W:0]    r_rx_cnt, w_rx_cnt_nxt;
   logic [3:0]        r_ticks, w_ticks_nxt;
   logic              r_rx_rda_prev;
   logic              r_rda;
   logic              r_rx_ovr;
   logic              r_tx_ovr;
   logic              r_load_pending;
   logic              r_tx_load;
   logic [7:0]        r_hold;
   logic [7:0]        r_rdata;
   logic [7:0]        r_tx_data;
   logic [7:0]        w_rd_mux;
   logic              w_rd;
   logic              w_wr;
   logic              w_cap;
   logic              w_rd_data;
   logic              w_rd_status;
   logic              w_wr_data;
   logic              w_tx_accept;

   assign w_rd        = iocs & iorw;
   assign w_wr        = iocs & ~iorw;
   assign w_cap       = rx_rda & ~r_rx_rda_prev;
   assign w_rd_data   = w_rd & (ioaddr == ADDR_DATA);
   assign w_rd_status = w_rd & (ioaddr == ADDR_STATUS);
   assign w_wr_data   = w_wr & (ioaddr == ADDR_DATA);
   assign w_tx_accept = w_wr_data & tbr_o;

   assign tbr_o      = tx_ready & ~r_load_pending;
   assign rda_o      = r_rda;
   assign rdata      = r_rdata;
   assign tx_data    = r_tx_data;
   assign tx_load    = r_tx_load;
   assign tx_baud_en = (r_tx_cnt == DIV_ZERO);
   assign rx_baud_en = (r_rx_state == RX_RUN) && (r_rx_cnt == EXT_ZERO);

   // Effective divisor never below 2 so the counters always have a reload gap.
   always_comb begin
      w_d     = (r_div < DIV_TWO) ? DIV_TWO : r_div;
      w_d_ext = {1'b0, w_d};
   end

   // Divisor zero-extended to 16 bits for byte-wise read and write.
   always_comb begin
      w_div16                = 16'd0;
      w_div16[DIV_W-1:0]     = r_div;
      w_div16_wr             = w_div16;
      if (w_wr && (ioaddr == ADDR_DB_LO)) begin
         w_div16_wr[7:0]     = wdata;
      end else if (w_wr && (ioaddr == ADDR_DB_HI)) begin
         w_div16_wr[15:8]    = wdata;
      end else begin
         w_div16_wr          = w_div16;
      end
   end

   // Read-data mux.
   always_comb begin
      w_rd_mux = 8'h00;
      case (ioaddr)
         ADDR_DATA:   w_rd_mux = r_hold;
         ADDR_STATUS: w_rd_mux = {4'b0000, r_tx_ovr, r_rx_ovr, tbr_o, r_rda};
         ADDR_DB_LO:  w_rd_mux = w_div16[7:0];
         ADDR_DB_HI:  w_rd_mux = w_div16[15:8];
         default:     w_rd_mux = 8'h00;
      endcase
   end

   // Free-running TX bit-tick counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_cnt <= DIV_W'(RESET_DIV - 1);
      end else if (r_tx_cnt == DIV_ZERO) begin
         r_tx_cnt <= w_d - DIV_ONE;
      end else begin
         r_tx_cnt <= r_tx_cnt - DIV_ONE;
      end
   end

   // RX FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= EXT_ZERO;
         r_ticks    <= 4'd0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_ticks    <= w_ticks_nxt;
      end
   end

   // RX FSM: first tick lands mid-bit 1.5 periods after the start edge, then 8 data + stop.
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt;
      w_ticks_nxt    = r_ticks;
      case (r_rx_state)
         RX_IDLE: begin
            if (!rxd) begin
               w_rx_cnt_nxt   = w_d_ext + (w_d_ext >> 1) - EXT_ONE;
               w_ticks_nxt    = 4'd0;
               w_rx_state_nxt = RX_RUN;
            end else begin
               w_rx_state_nxt = RX_IDLE;
            end
         end
         RX_RUN: begin
            if (r_rx_cnt == EXT_ZERO) begin
               w_rx_cnt_nxt = w_d_ext - EXT_ONE;
               w_ticks_nxt  = r_ticks + 4'd1;
               if (r_ticks == 4'd8) begin
                  w_rx_state_nxt = RX_STOP;
               end else begin
                  w_rx_state_nxt = RX_RUN;
               end
            end else begin
               w_rx_cnt_nxt = r_rx_cnt - EXT_ONE;
            end
         end
         RX_STOP: begin
            if (rxd) begin
               w_rx_state_nxt = RX_IDLE;
            end else begin
               w_rx_state_nxt = RX_STOP;
            end
         end
         default: begin
            w_rx_state_nxt = RX_IDLE;
         end
      endcase
   end

   // Bus registers, RX capture, sticky overrun flags and TX load sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div          <= DIV_W'(RESET_DIV);
         r_rx_rda_prev  <= 1'b0;
         r_hold         <= 8'h00;
         r_rda          <= 1'b0;
         r_rx_ovr       <= 1'b0;
         r_tx_ovr       <= 1'b0;
         r_load_pending <= 1'b0;
         r_tx_load      <= 1'b0;
         r_tx_data      <= 8'h00;
         r_rdata        <= 8'h00;
      end else begin
         r_div         <= w_div16_wr[DIV_W-1:0];
         r_rx_rda_prev <= rx_rda;
         r_tx_load     <= w_tx_accept;
         if (w_cap) begin
            r_hold <= rx_byte;
         end
         if (w_cap) begin
            r_rda <= 1'b1;
         end else if (w_rd_data) begin
            r_rda <= 1'b0;
         end
         // A byte arriving while the CPU drains the old one is not an overrun.
         if (w_cap && r_rda && !w_rd_data) begin
            r_rx_ovr <= 1'b1;
         end else if (w_rd_status) begin
            r_rx_ovr <= 1'b0;
         end
         if (w_wr_data && !tbr_o) begin
            r_tx_ovr <= 1'b1;
         end else if (w_rd_status) begin
            r_tx_ovr <= 1'b0;
         end
         if (w_tx_accept) begin
            r_load_pending <= 1'b1;
            r_tx_data      <= wdata;
         end else if (!tx_ready) begin
            r_load_pending <= 1'b0;
         end
         if (w_rd) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed self-checking bench for spart_bus_ctrl.
module tb_spart_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rda_o;
   logic       tbr_o;
   logic       rxd;
   logic [7:0] rx_byte;
   logic       rx_rda;
   logic       rx_baud_en;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_ready;
   logic       tx_baud_en;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   spart_bus_ctrl dut (
      .clk(clk), .reset(reset), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .wdata(wdata), .rdata(rdata), .rda_o(rda_o), .tbr_o(tbr_o), .rxd(rxd),
      .rx_byte(rx_byte), .rx_rda(rx_rda), .rx_baud_en(rx_baud_en),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .tx_baud_en(tx_baud_en)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      tick();
      iocs = 1'b0;
      d = rdata;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; wdata = d;
      tick();
      iocs = 1'b0; iorw = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; wdata = 8'h00;
      rxd = 1'b1; rx_byte = 8'h00; rx_rda = 1'b0; tx_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      vec_cnt++; if (rdata !== 8'h00) begin err_cnt++; $display("FAIL reset_rdata got %h want 00", rdata); end
      vec_cnt++; if (rda_o !== 1'b0) begin err_cnt++; $display("FAIL reset_rda got %b want 0", rda_o); end
      vec_cnt++; if (tbr_o !== 1'b1) begin err_cnt++; $display("FAIL reset_tbr got %b want 1", tbr_o); end
      vec_cnt++; if (tx_load !== 1'b0 || tx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_tx got load=%b data=%h want 0/00", tx_load, tx_data); end
      vec_cnt++; if (rx_baud_en !== 1'b0 || tx_baud_en !== 1'b0) begin err_cnt++; $display("FAIL reset_baud got rx=%b tx=%b want 0/0", rx_baud_en, tx_baud_en); end
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h02) begin err_cnt++; $display("FAIL reset_status got %h want 02", d); end
      bus_read(2'b10, d);
      vec_cnt++; if (d !== 8'h58) begin err_cnt++; $display("FAIL reset_db_lo got %h want 58", d); end
      bus_read(2'b11, d);
      vec_cnt++; if (d !== 8'h14) begin err_cnt++; $display("FAIL reset_db_hi got %h want 14", d); end
   endtask

   task automatic test_rx_baud();
      int n;
      int extra;
      bus_write(2'b10, 8'h04);
      bus_write(2'b11, 8'h00);
      rxd = 1'b0;
      n = 0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (rx_baud_en) begin
            vec_cnt++;
            if (k !== 6 + 4 * n) begin err_cnt++; $display("FAIL rx_tick_pos got cycle %0d want %0d", k, 6 + 4 * n); end
            n++;
         end
      end
      vec_cnt++; if (n !== 9) begin err_cnt++; $display("FAIL rx_tick_count got %0d want 9", n); end
      rxd = 1'b1;
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rx_baud_en) extra++;
      end
      vec_cnt++; if (extra !== 0) begin err_cnt++; $display("FAIL rx_idle_ticks got %0d want 0", extra); end
   endtask

   task automatic test_rx_capture();
      logic [7:0] d;
      rx_byte = 8'hA5; rx_rda = 1'b1;
      tick();
      vec_cnt++; if (rda_o !== 1'b1) begin err_cnt++; $display("FAIL cap_rda got %b want 1", rda_o); end
      rx_rda = 1'b0;
      tick();
      bus_read(2'b00, d);
      vec_cnt++; if (d !== 8'hA5) begin err_cnt++; $display("FAIL cap_data got %h want a5", d); end
      vec_cnt++; if (rda_o !== 1'b0) begin err_cnt++; $display("FAIL cap_rda_clr got %b want 0", rda_o); end
      rx_byte = 8'h11; rx_rda = 1'b1; tick(); rx_rda = 1'b0; tick();
      rx_byte = 8'h22; rx_rda = 1'b1; tick(); rx_rda = 1'b0; tick();
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h07) begin err_cnt++; $display("FAIL ovr_status got %h want 07", d); end
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h03) begin err_cnt++; $display("FAIL ovr_clear got %h want 03", d); end
      bus_read(2'b00, d);
      vec_cnt++; if (d !== 8'h22) begin err_cnt++; $display("FAIL ovr_data got %h want 22", d); end
      rx_byte = 8'h5A; rx_rda = 1'b1;
      bus_read(2'b00, d);
      rx_rda = 1'b0;
      vec_cnt++; if (d !== 8'h22 || rda_o !== 1'b1) begin err_cnt++; $display("FAIL same_cycle got data=%h rda=%b want 22/1", d, rda_o); end
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h03) begin err_cnt++; $display("FAIL same_cycle_status got %h want 03", d); end
      bus_read(2'b00, d);
      vec_cnt++; if (d !== 8'h5A) begin err_cnt++; $display("FAIL same_cycle_data got %h want 5a", d); end
   endtask

   task automatic test_tx();
      logic [7:0] d;
      tx_ready = 1'b1;
      bus_write(2'b00, 8'h3C);
      vec_cnt++; if (tx_load !== 1'b1 || tx_data !== 8'h3C || tbr_o !== 1'b0) begin err_cnt++; $display("FAIL tx_load got load=%b data=%h tbr=%b want 1/3c/0", tx_load, tx_data, tbr_o); end
      tick();
      vec_cnt++; if (tx_load !== 1'b0) begin err_cnt++; $display("FAIL tx_load_pulse got %b want 0", tx_load); end
      bus_write(2'b00, 8'h77);
      vec_cnt++; if (tx_load !== 1'b0 || tx_data !== 8'h3C) begin err_cnt++; $display("FAIL tx_drop got load=%b data=%h want 0/3c", tx_load, tx_data); end
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h08) begin err_cnt++; $display("FAIL tx_ovr_status got %h want 08", d); end
      tx_ready = 1'b0;
      tick();
      tx_ready = 1'b1;
      #1;
      vec_cnt++; if (tbr_o !== 1'b1) begin err_cnt++; $display("FAIL tbr_return got %b want 1", tbr_o); end
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h02) begin err_cnt++; $display("FAIL tx_ovr_clear got %h want 02", d); end
   endtask

   task automatic test_div_min();
      logic found;
      logic exp_en;
      bus_write(2'b11, 8'h00);
      bus_write(2'b10, 8'h00);
      found = 1'b0;
      for (int k = 0; k < 6000 && !found; k++) begin
         tick();
         if (tx_baud_en) found = 1'b1;
      end
      vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL div0_reload got %b want 1", found); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_en = ((k % 2) == 0) ? 1'b1 : 1'b0;
         vec_cnt++; if (tx_baud_en !== exp_en) begin err_cnt++; $display("FAIL div0_period k=%0d got %b want %b", k, tx_baud_en, exp_en); end
      end
      bus_write(2'b10, 8'h01);
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         if (tx_baud_en) found = 1'b1;
         else tick();
      end
      vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL div1_pulse got %b want 1", found); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_en = ((k % 2) == 0) ? 1'b1 : 1'b0;
         vec_cnt++; if (tx_baud_en !== exp_en) begin err_cnt++; $display("FAIL div1_period k=%0d got %b want %b", k, tx_baud_en, exp_en); end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] d;
      int extra;
      bus_write(2'b10, 8'h04);
      rxd = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 6) begin
            vec_cnt++; if (rx_baud_en !== 1'b1) begin err_cnt++; $display("FAIL midrun_first got %b want 1", rx_baud_en); end
         end
      end
      reset = 1'b1; rxd = 1'b1;
      tick();
      reset = 1'b0;
      vec_cnt++; if (rx_baud_en !== 1'b0) begin err_cnt++; $display("FAIL midrun_stop got %b want 0", rx_baud_en); end
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rx_baud_en) extra++;
      end
      vec_cnt++; if (extra !== 0) begin err_cnt++; $display("FAIL midrun_idle got %0d want 0", extra); end
      bus_read(2'b10, d);
      vec_cnt++; if (d !== 8'h58) begin err_cnt++; $display("FAIL midrun_div got %h want 58", d); end
      bus_read(2'b01, d);
      vec_cnt++; if (d !== 8'h02) begin err_cnt++; $display("FAIL midrun_status got %h want 02", d); end
   endtask

   initial begin
      test_reset();
      test_rx_baud();
      test_rx_capture();
      test_tx();
      test_div_min();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
